// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC register and PC+1 adder, selects the next fetch
// address (sequential / relative branch / absolute jump), and sequences
// start, halt, stall and instruction-memory wait states.
module pc_sequencer #(
  parameter int                    PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    WAIT_CYCLES  = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stall,
  input  logic                Jump,
  input  logic [PC_WIDTH-1:0] JumpTarget,
  input  logic                Branch,
  input  logic [PC_WIDTH-1:0] BranchOffset,
  input  logic                HaltInstr,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus1,
  output logic                FetchValid,
  output logic                Running,
  output logic                Halted,
  output logic [15:0]         RetiredCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Where every instruction boundary goes: through FETCH only when the
  // instruction memory needs wait states.
  localparam state_t     NXT         = (WAIT_CYCLES > 0) ? S_FETCH : S_EXEC;
  localparam int         WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_LOAD_I);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [3:0]          r_wait;
  logic [15:0]         r_retired;
  logic                r_fetch_valid;
  logic                r_running;
  logic                r_halted;

  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_pc_plus1;
  logic [3:0]          w_wait_nxt;
  logic                w_retire;
  logic                w_clr_cnt;

  assign w_pc_plus1 = r_pc + 1'b1;

  // Next-state / next-PC selection; EXEC decisions in priority order
  // stall > halt > jump > branch > sequential.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wait_nxt  = r_wait;
    w_retire    = 1'b0;
    w_clr_cnt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_pc_nxt    = RESET_VECTOR;
          w_clr_cnt   = 1'b1;
          w_state_nxt = NXT;
          w_wait_nxt  = WAIT_LOAD;
        end
      end
      S_FETCH: begin
        if (r_wait == 4'd0) w_state_nxt = S_EXEC;
        else                w_wait_nxt  = r_wait - 4'd1;
      end
      S_EXEC: begin
        if (Stall) begin
          // hold everything; the instruction stays presented
        end else if (HaltInstr) begin
          w_retire    = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = NXT;
          w_wait_nxt  = WAIT_LOAD;
          if (Jump)        w_pc_nxt = JumpTarget;
          else if (Branch) w_pc_nxt = w_pc_plus1 + BranchOffset;
          else             w_pc_nxt = w_pc_plus1;
        end
      end
      S_HALT: begin
        if (Start) begin
          w_pc_nxt    = w_pc_plus1;
          w_state_nxt = NXT;
          w_wait_nxt  = WAIT_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, PC, wait counter, retire counter and registered status flags.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VECTOR;
      r_wait        <= 4'd0;
      r_retired     <= 16'd0;
      r_fetch_valid <= 1'b0;
      r_running     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_wait        <= w_wait_nxt;
      if (w_clr_cnt)
        r_retired <= 16'd0;
      else if (w_retire && (r_retired != 16'hFFFF))
        r_retired <= r_retired + 16'd1;
      // flags track the state being entered so they match r_state exactly
      r_fetch_valid <= (w_state_nxt == S_EXEC);
      r_running     <= (w_state_nxt == S_EXEC) || (w_state_nxt == S_FETCH);
      r_halted      <= (w_state_nxt == S_HALT);
    end
  end

  assign PC           = r_pc;
  assign PCPlus1      = w_pc_plus1;
  assign FetchValid   = r_fetch_valid;
  assign Running      = r_running;
  assign Halted       = r_halted;
  assign RetiredCount = r_retired;

endmodule
